// File: rtl/cmd_seq.sv
// cmd_seq: three-byte host command sequencer. It collects opcode/byte2/byte3
// from the UART receiver, then either drives an SPI transaction, starts a
// channel dump or updates a local register, and returns a response byte.
// Build option: define CMD_SEQ_TIMEOUT_EN to add a 16-bit watchdog on the
// SPI_WAIT, DUMP_WAIT and RESP_WAIT states.
module cmd_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rdy,
  output logic        clr_rdy,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        spi_wrt,
  output logic [15:0] spi_cmd,
  output logic [2:0]  spi_sel,
  input  logic        spi_done,
  input  logic [15:0] spi_rd_data,
  output logic        dump_req,
  output logic [1:0]  dump_ch,
  input  logic        dump_done,
  output logic [12:0] trig_pos,
  output logic [3:0]  decimator,
  output logic [5:0]  trig_cfg
);

  typedef enum logic [2:0] {
    IDLE, RX2, RX3, DISPATCH, SPI_WAIT, DUMP_WAIT, RESP, RESP_WAIT
  } state_t;

  localparam logic [7:0] ACK = 8'hA5;
  localparam logic [7:0] NAK = 8'hEE;

  state_t      state, state_nxt;
  logic [7:0]  opcode;
  logic [5:0]  byte2;
  logic [7:0]  byte3;

  logic [15:0] spi_cmd_q, dec_cmd;
  logic [2:0]  spi_sel_q, dec_sel;
  logic        dec_is_spi;
  logic [1:0]  dump_ch_q;

  logic [7:0]  resp_nxt;
  logic        resp_ld, spi_ld, dump_ld, pos_ld, dec_ld, cfg_ld;
  logic        wd_hit;

  // Gain pot wiper settings indexed by the 3-bit gain code.
  function automatic logic [7:0] gain_lut(input logic [2:0] idx);
    case (idx)
      3'd0:    gain_lut = 8'h02;
      3'd1:    gain_lut = 8'h05;
      3'd2:    gain_lut = 8'h09;
      3'd3:    gain_lut = 8'h14;
      3'd4:    gain_lut = 8'h28;
      3'd5:    gain_lut = 8'h4B;
      3'd6:    gain_lut = 8'h96;
      default: gain_lut = 8'hE6;
    endcase
  endfunction

  // Decode the captured command into an SPI word/select when it is a valid SPI command.
  always_comb begin
    dec_is_spi = 1'b0;
    dec_cmd    = '0;
    dec_sel    = '0;
    case (opcode)
      8'h02: if (byte2[1:0] != 2'd0) begin
        dec_is_spi = 1'b1;
        dec_sel    = {1'b0, byte2[1:0]};
        dec_cmd    = {8'h13, gain_lut(byte2[4:2])};
      end
      8'h03: if (byte3 >= 8'd46 && byte3 <= 8'd201) begin
        dec_is_spi = 1'b1;
        dec_sel    = 3'd0;
        dec_cmd    = {8'h13, byte3};
      end
      8'h08: begin
        dec_is_spi = 1'b1;
        dec_sel    = 3'd4;
        dec_cmd    = {2'b01, byte2[5:0], byte3};
      end
      8'h09: begin
        dec_is_spi = 1'b1;
        dec_sel    = 3'd4;
        dec_cmd    = {2'b00, byte2[5:0], 8'h00};
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and single-cycle strobes.
  always_comb begin
    state_nxt = state;
    clr_rdy   = 1'b0;
    trmt      = 1'b0;
    spi_wrt   = 1'b0;
    dump_req  = 1'b0;
    resp_ld   = 1'b0;
    resp_nxt  = NAK;
    spi_ld    = 1'b0;
    dump_ld   = 1'b0;
    pos_ld    = 1'b0;
    dec_ld    = 1'b0;
    cfg_ld    = 1'b0;
    case (state)
      IDLE: if (rdy) begin
        clr_rdy   = rst_n;
        state_nxt = RX2;
      end
      RX2: if (rdy) begin
        clr_rdy   = rst_n;
        state_nxt = RX3;
      end
      RX3: if (rdy) begin
        clr_rdy   = rst_n;
        state_nxt = DISPATCH;
      end
      DISPATCH: begin
        if (dec_is_spi) begin
          spi_wrt   = 1'b1;
          spi_ld    = 1'b1;
          state_nxt = SPI_WAIT;
        end else begin
          resp_ld   = 1'b1;
          resp_nxt  = ACK;
          state_nxt = RESP;
          case (opcode)
            8'h01: begin
              resp_ld   = 1'b0;
              dump_req  = 1'b1;
              dump_ld   = 1'b1;
              state_nxt = DUMP_WAIT;
            end
            8'h04:   pos_ld = 1'b1;
            8'h05:   dec_ld = 1'b1;
            8'h06:   cfg_ld = 1'b1;
            8'h07:   resp_nxt = {2'b00, trig_cfg};
            default: resp_nxt = NAK;
          endcase
        end
      end
      SPI_WAIT: begin
        if (spi_done) begin
          resp_ld   = 1'b1;
          resp_nxt  = (opcode == 8'h09) ? spi_rd_data[7:0] : ACK;
          state_nxt = RESP;
        end else if (wd_hit) begin
          resp_ld   = 1'b1;
          resp_nxt  = NAK;
          state_nxt = RESP;
        end
      end
      DUMP_WAIT: begin
        if (dump_done) begin
          state_nxt = IDLE;
        end else if (wd_hit) begin
          resp_ld   = 1'b1;
          resp_nxt  = NAK;
          state_nxt = RESP;
        end
      end
      RESP: begin
        trmt      = 1'b1;
        state_nxt = RESP_WAIT;
      end
      RESP_WAIT: if (tx_done || wd_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // SPI word/select and dump channel are presented combinationally during
  // DISPATCH so they are valid alongside the start pulse, then held in flops.
  assign spi_cmd = spi_ld  ? dec_cmd     : spi_cmd_q;
  assign spi_sel = spi_ld  ? dec_sel     : spi_sel_q;
  assign dump_ch = dump_ld ? byte2[1:0]  : dump_ch_q;

  // Command byte capture, held SPI/dump outputs, response byte and registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode    <= '0;
      byte2     <= '0;
      byte3     <= '0;
      spi_cmd_q <= '0;
      spi_sel_q <= '0;
      dump_ch_q <= '0;
      tx_data   <= '0;
      trig_pos  <= 13'd256;
      decimator <= '0;
      trig_cfg  <= '0;
    end else begin
      if (clr_rdy) begin
        case (state)
          IDLE:    opcode <= rx_data;
          RX2:     byte2  <= rx_data[5:0];
          default: byte3  <= rx_data;
        endcase
      end
      if (spi_ld) begin
        spi_cmd_q <= dec_cmd;
        spi_sel_q <= dec_sel;
      end
      if (dump_ld) dump_ch_q <= byte2[1:0];
      if (resp_ld) tx_data   <= resp_nxt;
      if (pos_ld)  trig_pos  <= {byte2[4:0], byte3};
      if (dec_ld)  decimator <= byte3[3:0];
      if (cfg_ld)  trig_cfg  <= byte2[5:0];
    end
  end

`ifdef CMD_SEQ_TIMEOUT_EN
  logic [15:0] wd_cnt;

  // Watchdog: restarts on every state change, counts only while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      wd_cnt <= '0;
    else if (state_nxt != state)
      wd_cnt <= '0;
    else if (state == SPI_WAIT || state == DUMP_WAIT || state == RESP_WAIT)
      wd_cnt <= wd_cnt + 16'd1;
  end

  assign wd_hit = (wd_cnt == 16'hFFFF) &&
                  (state == SPI_WAIT || state == DUMP_WAIT || state == RESP_WAIT);
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: doc/cmd_seq.md
CMD_SEQ -- requirements
Module: cmd_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as listed below.
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  byte received from host UART
- rdy  input  1  rx_data valid, held until cleared
- clr_rdy  output  1  one-cycle pulse acknowledging rx_data
- tx_data  output  8  response byte to host UART
- trmt  output  1  one-cycle pulse starting a UART transmit
- tx_done  input  1  UART transmit complete
- spi_wrt  output  1  one-cycle pulse starting a 16-bit SPI transaction
- spi_cmd  output  16  SPI word
- spi_sel  output  3  slave select: 0 trig pot, 1 ch1 pot, 2 ch2 pot, 3 ch3 pot, 4 EEPROM
- spi_done  input  1  SPI transaction complete
- spi_rd_data  input  16  word shifted in during the last SPI transaction
- dump_req  output  1  one-cycle pulse starting a channel dump
- dump_ch  output  2  channel to dump
- dump_done  input  1  dump engine finished
- trig_pos  output  13  trigger position register
- decimator  output  4  decimator exponent register
- trig_cfg  output  6  trigger configuration register

Function
REQ-002 The block SHALL collect a command of three bytes (opcode, byte2, byte3), accepting each byte on rdy=1 and pulsing clr_rdy in the same cycle that the byte is captured.
REQ-003 The states SHALL be IDLE, RX2, RX3, DISPATCH, SPI_WAIT, DUMP_WAIT, RESP and RESP_WAIT; rdy SHALL be ignored outside IDLE, RX2 and RX3.
REQ-004 DISPATCH SHALL be entered one cycle after byte3 is captured and SHALL decode the opcode:
- 01 DUMP: dump_ch=byte2[1:0], pulse dump_req, go to DUMP_WAIT; on dump_done return to IDLE with no response byte.
- 02 CFG_GAIN: byte2[1:0]=0 is a NAK; otherwise spi_sel=byte2[1:0], spi_cmd={8'h13, LUT[byte2[4:2]]}, with LUT = 02,05,09,14,28,4B,96,E6.
- 03 TRIG_LVL: byte3 outside 46..201 is a NAK; otherwise spi_sel=0 and spi_cmd={8'h13, byte3}.
- 04 TRIG_POS: trig_pos={byte2[4:0], byte3}, then ACK.
- 05 SET_DEC: decimator=byte3[3:0], then ACK.
- 06 TRIG_CFG: trig_cfg=byte2[5:0], then ACK.
- 07 TRIG_RD: respond with {2'b00, trig_cfg}.
- 08 EEP_WRT: spi_sel=4 and spi_cmd={2'b01, byte2[5:0], byte3}.
- 09 EEP_RD: spi_sel=4 and spi_cmd={2'b00, byte2[5:0], 8'h00}.
- any other opcode: NAK.
REQ-005 For SPI commands, spi_wrt SHALL pulse in DISPATCH, and spi_cmd and spi_sel SHALL be held stable until spi_done; on spi_done the response SHALL be ACK, or spi_rd_data[7:0] for EEP_RD.
REQ-006 ACK SHALL be 8'hA5 and NAK SHALL be 8'hEE.
REQ-007 In RESP, tx_data SHALL be set and trmt SHALL pulse once; RESP_WAIT SHALL hold until tx_done and then return to IDLE.
REQ-008 A register command (04/05/06/07) SHALL update its register in the DISPATCH cycle, and trmt SHALL assert exactly 2 cycles after byte3 is captured.
REQ-009 A NAK command SHALL leave all registers and SPI outputs unchanged.
REQ-010 spi_done, dump_done or tx_done arriving in any state other than the one waiting for it SHALL be ignored.
REQ-011 If rdy and a done input assert in the same cycle, each SHALL be handled per its own state rule; no event is queued.

Reset
REQ-012 While rst_n=0, all outputs SHALL be 0 except trig_pos=13'd256; the state SHALL be IDLE.
REQ-013 Reset asserted mid-command SHALL discard any partial bytes and any pending SPI, dump or response activity.

Configuration
REQ-014 The macro CMD_SEQ_TIMEOUT_EN SHALL control a wait-state watchdog.
- Macro defined: a 16-bit counter SHALL clear on entry to SPI_WAIT, DUMP_WAIT or RESP_WAIT. On reaching 16'hFFFF in SPI_WAIT or DUMP_WAIT the block SHALL go to RESP with NAK; in RESP_WAIT it SHALL go to IDLE.
- Macro undefined: there SHALL be no counter, and the block SHALL wait indefinitely.

Verification
REQ-015 Send 05 00 03 -> decimator=3, response A5.
REQ-016 Send 03 00 2D -> response EE, no spi_wrt; then send 03 00 80 -> spi_sel=0, spi_cmd=1380, response A5 after spi_done.
REQ-017 Send 02 0E 00 (ch2, gain 3) -> spi_sel=2, spi_cmd=1314, response A5; send 02 0C 00 -> response EE.
REQ-018 Send 08 05 C3, then 09 05 00 with the EEPROM model -> spi_cmd=45C3 then 0500, second response C3.
REQ-019 Send 01 01 00 -> dump_req pulse with dump_ch=1 and no tx until dump_done; then send 07 00 00 after 06 2A 00 -> response 2A.
REQ-020 Assert rst_n low after byte2 of 04 12 34 -> trig_pos=256; the next full command is decoded correctly.
